// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_pkg                                                         |
// | Brief    : Shared widths, default raster size and arbiter state encoding   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package vga_pkg;
  localparam int X_W       = 9;
  localparam int Y_W       = 8;
  localparam int COLOR_W   = 3;
  localparam int DEF_H_RES = 320;
  localparam int DEF_V_RES = 240;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    GRANT = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                      |
// | Brief    : Combinational round-robin pick: first request at/after pointer  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] pointer,
  output logic [N-1:0]     winner,
  output logic [PTR_W-1:0] winner_idx
);
  logic w_found;

  // Upper pass covers pointer..N-1, the second pass wraps to 0..pointer-1.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    w_found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && req[i] && (PTR_W'(i) >= pointer)) begin
        w_found    = 1'b1;
        winner[i]  = 1'b1;
        winner_idx = PTR_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_found && req[i] && (PTR_W'(i) < pointer)) begin
        w_found    = 1'b1;
        winner[i]  = 1'b1;
        winner_idx = PTR_W'(i);
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/vga_plot_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : vga_plot_arbiter                                                |
// | Brief    : Owns the VGA pixel-write port: frame clear, then RR draw bursts |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int H_RES     = DEF_H_RES,
  parameter int V_RES     = DEF_V_RES,
  parameter int MAX_BURST = 256
) (
  input  logic                       CLOCK_50,
  input  logic                       rstn,
  input  logic                       frame_tick,
  input  logic                       game_display_en,
  input  logic [COLOR_W-1:0]         background_color,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         pix_valid,
  input  logic [NUM_REQ-1:0]         pix_last,
  input  logic [X_W*NUM_REQ-1:0]     pix_x,
  input  logic [Y_W*NUM_REQ-1:0]     pix_y,
  input  logic [COLOR_W*NUM_REQ-1:0] pix_color,
  output logic [NUM_REQ-1:0]         grant,
  output logic [X_W-1:0]             VGA_X,
  output logic [Y_W-1:0]             VGA_Y,
  output logic [COLOR_W-1:0]         VGA_COLOR,
  output logic                       plot_enable,
  output logic                       clear_busy,
  output logic                       clear_done
);
  localparam int c_ptr_w   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_burst_w = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [X_W-1:0]       c_x_last     = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]       c_y_last     = Y_W'(V_RES - 1);
  localparam logic [c_burst_w-1:0] c_burst_last = c_burst_w'(MAX_BURST - 1);
  localparam logic [c_ptr_w-1:0]   c_ptr_max    = c_ptr_w'(NUM_REQ - 1);

  state_t               r_state, w_state_nxt;
  logic                 r_pending;
  logic [c_ptr_w-1:0]   r_ptr, r_gidx;
  logic [NUM_REQ-1:0]   r_grant;
  logic [c_burst_w-1:0] r_burst;
  logic [X_W-1:0]       r_x_cnt, r_vga_x;
  logic [Y_W-1:0]       r_y_cnt, r_vga_y;
  logic [COLOR_W-1:0]   r_vga_color;
  logic                 r_plot, r_clear_last, r_clear_done;

  logic                 w_start_clear, w_start_grant, w_accept, w_release, w_sweep_end;
  logic [NUM_REQ-1:0]   w_winner;
  logic [c_ptr_w-1:0]   w_winner_idx;
  logic [X_W-1:0]       w_x   [NUM_REQ];
  logic [Y_W-1:0]       w_y   [NUM_REQ];
  logic [COLOR_W-1:0]   w_col [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_x[gi]   = pix_x[gi*X_W +: X_W];
      assign w_y[gi]   = pix_y[gi*Y_W +: Y_W];
      assign w_col[gi] = pix_color[gi*COLOR_W +: COLOR_W];
    end
  endgenerate

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (c_ptr_w)
  ) u_rr (
    .req        (req),
    .pointer    (r_ptr),
    .winner     (w_winner),
    .winner_idx (w_winner_idx)
  );

  always_ff @(posedge CLOCK_50 or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Clear outranks every requester; leaving IDLE is the only thing the enable gates.
  always_comb begin
    w_state_nxt   = r_state;
    w_start_clear = 1'b0;
    w_start_grant = 1'b0;
    w_accept      = 1'b0;
    w_release     = 1'b0;
    w_sweep_end   = 1'b0;
    case (r_state)
      IDLE: begin
        if (game_display_en && r_pending) begin
          w_start_clear = 1'b1;
          w_state_nxt   = CLEAR;
        end else if (game_display_en && (|req)) begin
          w_start_grant = 1'b1;
          w_state_nxt   = GRANT;
        end
      end
      CLEAR: begin
        w_sweep_end = (r_x_cnt == c_x_last) && (r_y_cnt == c_y_last);
        if (w_sweep_end) w_state_nxt = IDLE;
      end
      GRANT: begin
        w_accept  = pix_valid[r_gidx];
        w_release = (w_accept && pix_last[r_gidx]) || !req[r_gidx] ||
                    (r_burst == c_burst_last);
        if (w_release) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rstn) begin
    if (!rstn) begin
      r_pending    <= 1'b0;
      r_ptr        <= '0;
      r_gidx       <= '0;
      r_grant      <= '0;
      r_burst      <= '0;
      r_x_cnt      <= '0;
      r_y_cnt      <= '0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_color  <= '0;
      r_plot       <= 1'b0;
      r_clear_last <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_clear_last <= w_sweep_end;
      r_clear_done <= r_clear_last;

      if (w_start_clear)                       r_pending <= 1'b0;
      else if (frame_tick && r_state != CLEAR) r_pending <= 1'b1;

      if (w_start_grant) begin
        r_grant <= w_winner;
        r_gidx  <= w_winner_idx;
      end else if (w_release) begin
        r_grant <= '0;
        r_ptr   <= (r_gidx == c_ptr_max) ? '0 : r_gidx + c_ptr_w'(1);
      end

      r_burst <= (r_state == GRANT) ? r_burst + c_burst_w'(1) : '0;

      if (r_state == CLEAR) begin
        if (r_x_cnt == c_x_last) begin
          r_x_cnt <= '0;
          r_y_cnt <= w_sweep_end ? '0 : r_y_cnt + Y_W'(1);
        end else begin
          r_x_cnt <= r_x_cnt + X_W'(1);
        end
      end

      // Every write lands on the adapter one cycle after it is presented.
      r_plot <= 1'b0;
      if (r_state == CLEAR) begin
        r_plot      <= 1'b1;
        r_vga_x     <= r_x_cnt;
        r_vga_y     <= r_y_cnt;
        r_vga_color <= background_color;
      end else if (w_accept) begin
        r_plot      <= 1'b1;
        r_vga_x     <= w_x[r_gidx];
        r_vga_y     <= w_y[r_gidx];
        r_vga_color <= w_col[r_gidx];
      end
    end
  end

  assign grant       = r_grant;
  assign VGA_X       = r_vga_x;
  assign VGA_Y       = r_vga_y;
  assign VGA_COLOR   = r_vga_color;
  assign plot_enable = r_plot;
  assign clear_busy  = (r_state == CLEAR);
  assign clear_done  = r_clear_done;
endmodule
`default_nettype wire

// File: tb/tb_vga_plot_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_vga_plot_arbiter                                             |
// | Brief    : Directed + randomized bench for vga_plot_arbiter (8x4, burst 4) |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_vga_plot_arbiter;
  localparam int N  = 4;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rstn, frame_tick, en;
  logic [2:0]  bg;
  logic [3:0]  req, pv, pl;
  logic [35:0] px;
  logic [31:0] py;
  logic [11:0] pc;
  logic [3:0]  grant;
  logic [8:0]  VGA_X;
  logic [7:0]  VGA_Y;
  logic [2:0]  VGA_COLOR;
  logic        plot_enable, clear_busy, clear_done;

  int n_checks = 0;
  int n_err    = 0;
  int m_ptr;
  logic [3:0] cur_mask;
  int plan_len [N];
  int valid_pct, abort_pct, tick_at;

  always #5 clk = ~clk;

  vga_plot_arbiter #(.NUM_REQ(N), .H_RES(H), .V_RES(V), .MAX_BURST(MB)) dut (
    .CLOCK_50         (clk),
    .rstn             (rstn),
    .frame_tick       (frame_tick),
    .game_display_en  (en),
    .background_color (bg),
    .req              (req),
    .pix_valid        (pv),
    .pix_last         (pl),
    .pix_x            (px),
    .pix_y            (py),
    .pix_color        (pc),
    .grant            (grant),
    .VGA_X            (VGA_X),
    .VGA_Y            (VGA_Y),
    .VGA_COLOR        (VGA_COLOR),
    .plot_enable      (plot_enable),
    .clear_busy       (clear_busy),
    .clear_done       (clear_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference RR rule: lowest offset from the pointer, wrapping, wins.
  function automatic logic [3:0] rr_pick(input logic [3:0] m, input int p);
    logic [3:0] r;
    r = '0;
    for (int k = N - 1; k >= 0; k--)
      if (m[(p + k) % N]) r = 4'(1) << ((p + k) % N);
    return r;
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic junk();
    pv = 4'($urandom);
    pl = 4'($urandom);
    px = 36'({$urandom(), $urandom()});
    py = $urandom;
    pc = 12'($urandom);
  endtask

  // Requester g serves its grant; every valid pixel must appear one cycle later.
  task automatic do_burst(input int g);
    int sent;
    bit v, l, ab, rel;
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
    sent = 0;
    for (int k = 0; k < MB; k++) begin
      chk("burst_grant", grant, 4'(1) << g);
      junk();
      v  = ($urandom_range(0, 99) < valid_pct);
      ab = ($urandom_range(0, 99) < abort_pct);
      l  = (sent == plan_len[g] - 1);
      x  = 9'($urandom);
      y  = 8'($urandom);
      c  = 3'($urandom);
      pv[g] = v;
      pl[g] = v ? l : 1'($urandom);
      px[g*9 +: 9] = x;
      py[g*8 +: 8] = y;
      pc[g*3 +: 3] = c;
      req = cur_mask;
      if (ab) req[g] = 1'b0;
      frame_tick = (k == tick_at);
      rel = (v && l) || ab || (k == MB - 1);
      if (v) sent++;
      step();
      frame_tick = 1'b0;
      req = cur_mask;
      chk("burst_pe", plot_enable, v);
      if (v) begin
        chk("burst_x", VGA_X, x);
        chk("burst_y", VGA_Y, y);
        chk("burst_col", VGA_COLOR, c);
      end
      if (rel) begin
        chk("release_grant", grant, 0);
        break;
      end
    end
    m_ptr = (g + 1) % N;
  endtask

  task automatic arb_round(input logic [3:0] mask);
    logic [3:0] e;
    cur_mask = mask;
    req = mask;
    junk();
    e = rr_pick(mask, m_ptr);
    step();
    chk("arb_grant", grant, e);
    chk("arb_gap_pe", plot_enable, 0);
    do_burst(onehot_idx(e));
  endtask

  // Expects a full raster sweep; colour is whatever bg held the cycle before.
  task automatic expect_clear(input logic [2:0] base, input bit vary);
    int w;
    logic [2:0] col;
    w = 0;
    while (clear_busy !== 1'b1 && w < 4) begin
      step();
      w++;
    end
    chk("clear_start", clear_busy, 1);
    for (int i = 0; i < H * V; i++) begin
      col = vary ? 3'($urandom) : base;
      bg = col;
      junk();
      step();
      chk("clr_pe", plot_enable, 1);
      chk("clr_x", VGA_X, i % H);
      chk("clr_y", VGA_Y, i / H);
      chk("clr_col", VGA_COLOR, col);
      chk("clr_grant", grant, 0);
      chk("clr_busy", clear_busy, (i < H * V - 1));
      chk("clr_done_early", clear_done, 0);
    end
    step();
    chk("clr_done", clear_done, 1);
    chk("clr_end_pe", plot_enable, 0);
    chk("clr_end_busy", clear_busy, 0);
  endtask

  initial begin
    rstn = 1'b0; frame_tick = 1'b0; en = 1'b1; bg = 3'b000;
    req = '0; cur_mask = '0; pv = '0; pl = '0; px = '0; py = '0; pc = '0;
    m_ptr = 0; valid_pct = 100; abort_pct = 0; tick_at = -1;
    for (int i = 0; i < N; i++) plan_len[i] = 3;

    // Reset state and quiet idle.
    step(); step();
    chk("rst_grant", grant, 0);
    chk("rst_x", VGA_X, 0);
    chk("rst_y", VGA_Y, 0);
    chk("rst_col", VGA_COLOR, 0);
    chk("rst_pe", plot_enable, 0);
    chk("rst_busy", clear_busy, 0);
    chk("rst_done", clear_done, 0);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      junk();
      step();
      chk("idle_pe", plot_enable, 0);
      chk("idle_grant", grant, 0);
    end

    // Background clear.
    frame_tick = 1'b1; bg = 3'b101;
    step();
    frame_tick = 1'b0;
    expect_clear(3'b101, 1'b0);
    step();
    chk("clr_done_pulse", clear_done, 0);

    // Alternating bursts between requesters 0 and 2.
    arb_round(4'b0101);
    arb_round(4'b0101);
    arb_round(4'b0101);

    // Frame tick mid-burst: burst completes, clear runs, then requester 2.
    tick_at = 1;
    arb_round(4'b0110);
    tick_at = -1;
    expect_clear(3'b000, 1'b1);
    chk("post_clear_grant", grant, rr_pick(4'b0110, m_ptr));
    do_burst(2);

    // Burst cap forces release.
    plan_len[0] = 99; plan_len[1] = 2;
    arb_round(4'b0011);
    arb_round(4'b0011);

    // Asynchronous reset in the middle of a clear drops the pending work.
    cur_mask = '0; req = '0; frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    for (int i = 0; i < 6; i++) step();
    #2;
    rstn = 1'b0;
    #1;
    chk("async_grant", grant, 0);
    chk("async_x", VGA_X, 0);
    chk("async_y", VGA_Y, 0);
    chk("async_col", VGA_COLOR, 0);
    chk("async_pe", plot_enable, 0);
    chk("async_busy", clear_busy, 0);
    chk("async_done", clear_done, 0);
    step();
    rstn = 1'b1;
    m_ptr = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_pe", plot_enable, 0);
      chk("post_rst_busy", clear_busy, 0);
    end

    // Display disabled holds everything in idle; enabling runs clear first.
    en = 1'b0; frame_tick = 1'b1; cur_mask = 4'b1111; req = 4'b1111;
    step();
    frame_tick = 1'b0;
    for (int i = 0; i < 6; i++) begin
      junk();
      step();
      chk("dis_grant", grant, 0);
      chk("dis_pe", plot_enable, 0);
      chk("dis_busy", clear_busy, 0);
    end
    en = 1'b1;
    expect_clear(3'b010, 1'b0);
    chk("en_grant", grant, rr_pick(4'b1111, m_ptr));
    plan_len[0] = 2;
    do_burst(0);

    // Randomized arbitration rounds with gaps, aborts and truncation.
    valid_pct = 70; abort_pct = 12;
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) plan_len[i] = $urandom_range(1, 6);
      arb_round(4'($urandom_range(1, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
`default_nettype wire
